// File: rtl/alu_op_dispatch_if.sv
// Issue/return bundle between the ALU issue stage, the operand demux and the functional units.
// The slave modport is the dispatcher's view; the master modport is the surrounding ALU.
interface alu_op_dispatch_if #(
   parameter int DW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [DW-1:0] in_data;
   logic [DW-1:0] dmx_a;
   logic [2:0]    dmx_sel;
   logic [7:0]    unit_done;
   logic [DW-1:0] unit_result;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic [2:0]    res_op;
   logic          res_timeout;

   modport slave (
      input  in_valid, in_op, in_data, unit_done, unit_result, res_ready,
      output in_ready, dmx_a, dmx_sel, res_valid, res_data, res_op, res_timeout
   );

   modport master (
      output in_valid, in_op, in_data, unit_done, unit_result, res_ready,
      input  in_ready, dmx_a, dmx_sel, res_valid, res_data, res_op, res_timeout
   );
endinterface

// File: rtl/alu_op_dispatch.sv
// Issue stage in front of the 1-to-8 operand demux: accepts one op, holds the demux
// inputs until the selected unit reports done (or times out), then returns the result.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// BUSY  | demux driven with held operand/select, waiting for unit_done[dmx_sel] or timeout
// RESP  | result (or abort) presented on res_*, waiting for res_ready
module alu_op_dispatch #(
   parameter int DW        = 16,
   parameter int TO_CYCLES = 255
) (
   input logic               clk,
   input logic               rst_n,
   alu_op_dispatch_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

   state_t      state;
   logic [15:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         bus.in_ready    <= 1'b1;
         bus.dmx_a       <= '0;
         bus.dmx_sel     <= '0;
         bus.res_valid   <= 1'b0;
         bus.res_data    <= '0;
         bus.res_op      <= '0;
         bus.res_timeout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  bus.dmx_sel  <= bus.in_op;
                  bus.dmx_a    <= bus.in_data;
                  bus.in_ready <= 1'b0;
                  cnt          <= '0;
                  state        <= BUSY;
               end
            end
            BUSY: begin
               // Only the selected unit can complete; done beats a coincident timeout.
               if (bus.unit_done[bus.dmx_sel]) begin
                  bus.res_data    <= bus.unit_result;
                  bus.res_op      <= bus.dmx_sel;
                  bus.res_timeout <= 1'b0;
                  bus.res_valid   <= 1'b1;
                  bus.dmx_a       <= '0;
                  state           <= RESP;
               end else if (cnt == TO_LAST) begin
                  bus.res_data    <= '0;
                  bus.res_op      <= bus.dmx_sel;
                  bus.res_timeout <= 1'b1;
                  bus.res_valid   <= 1'b1;
                  bus.dmx_a       <= '0;
                  state           <= RESP;
               end else if (cnt != 16'hFFFF) begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP: begin
               // dmx_sel stays put so the demux outputs do not glitch between ops.
               if (bus.res_ready) begin
                  bus.res_valid   <= 1'b0;
                  bus.res_timeout <= 1'b0;
                  bus.in_ready    <= 1'b1;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
